// File: rtl/control_path_if.sv
// ---------------------------------------------------------------------------
// control_path_if
//
// Bundles the instruction-input handshake and the control outputs of
// control_path so the control unit and its consumers share one port.
//
// Signals:
//   instrword  32  instruction word, captured when newinstr is high
//   newinstr    1  start a new instruction (level, sampled every edge)
//   RegDst      1  write register select: 1 = rd, 0 = rt
//   ALUSrc      1  1 = sign-extended immediate, 0 = rt
//   MemtoReg    1  1 = writeback from memory
//   ALUCtrl     4  ALU operation code
//   Branch      1  beq indicator, EX cycle only
//   MemRead     1  one-cycle strobe in MEM
//   MemWrite    1  one-cycle strobe in MEM
//   RegWrite    1  one-cycle strobe in WB
//   busy        1  an instruction is in flight
//   done        1  WB cycle
//   illegal     1  unsupported opcode/funct (detection build only)
//
// Modports:
//   master - instruction source / datapath side (drives instrword, newinstr)
//   slave  - control_path side (drives all control outputs)
// ---------------------------------------------------------------------------
interface control_path_if;
    logic [31:0] instrword;
    logic        newinstr;
    logic        RegDst;
    logic        ALUSrc;
    logic        MemtoReg;
    logic [3:0]  ALUCtrl;
    logic        Branch;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        busy;
    logic        done;
    logic        illegal;

    modport master (
        output instrword, newinstr,
        input  RegDst, ALUSrc, MemtoReg, ALUCtrl, Branch,
        input  MemRead, MemWrite, RegWrite, busy, done, illegal
    );

    modport slave (
        input  instrword, newinstr,
        output RegDst, ALUSrc, MemtoReg, ALUCtrl, Branch,
        output MemRead, MemWrite, RegWrite, busy, done, illegal
    );
endinterface

// File: rtl/control_path.sv
// ---------------------------------------------------------------------------
// control_path
//
// Multi-cycle control unit for the MIPS subset (R-type, lw, sw, beq).
// Captures an instruction word when newinstr is high, then walks
// ID -> EX -> MEM -> WB -> IDLE, presenting level controls for the whole
// instruction and single-cycle Branch / MemRead / MemWrite / RegWrite
// strobes in the phase where the datapath needs them.
//
// Ports:
//   clock  in   sole clock, rising edge
//   reset  in   synchronous, active-low; dominates newinstr
//   bus    slave modport of control_path_if (instrword/newinstr in,
//               all control outputs out)
//
// Configuration:
//   CTRL_ILLEGAL_DETECT_EN - when defined, unsupported opcodes and R-type
//   words with an unlisted funct raise `illegal` while busy and have all of
//   their strobes and Branch suppressed. When undefined, `illegal` is tied
//   low, unknown opcodes behave as nop and unlisted functs execute as add.
// ---------------------------------------------------------------------------
module control_path (
    input  logic           clock,
    input  logic           reset,
    control_path_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ID   = 3'd1,
        EX   = 3'd2,
        MEM  = 3'd3,
        WB   = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;

    // All outputs are registered: they are computed from the next-state
    // values (instr_d, state_d), so each output flop holds exactly the
    // decode of the instr_q/state_q pair that becomes current at that edge.
    logic       reg_dst_q,   reg_dst_d;
    logic       alu_src_q,   alu_src_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic [3:0] alu_ctrl_q,  alu_ctrl_d;
    logic       branch_q,    branch_d;
    logic       mem_read_q,  mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       reg_write_q, reg_write_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;
    logic       illegal_q,   illegal_d;

    // Main decode fields of the instruction that will be current next cycle.
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       dec_reg_dst, dec_alu_src, dec_mem_to_reg;
    logic       dec_reg_write, dec_mem_read, dec_mem_write, dec_branch;
    logic [1:0] alu_op;
    logic       suppress;

    // Next-state, instruction capture and full output decode.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;

        if (!reset) begin
            state_d = IDLE;
            instr_d = '0;
        end else if (bus.newinstr) begin
            // Capture restarts sequencing from any state; strobes of an
            // aborted instruction that have not yet fired are simply lost.
            instr_d = bus.instrword;
            state_d = ID;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                ID:      state_d = EX;
                EX:      state_d = MEM;
                MEM:     state_d = WB;
                WB:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        opcode = instr_d[31:26];
        funct  = instr_d[5:0];

        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_branch     = 1'b0;
        alu_op         = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                alu_op        = 2'b10;
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_branch = 1'b1;
                alu_op     = 2'b01;
            end
            default: ;
        endcase

        alu_ctrl_d = 4'b0010;
        case (alu_op)
            2'b01: alu_ctrl_d = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100000: alu_ctrl_d = 4'b0010;
                    6'b100010: alu_ctrl_d = 4'b0110;
                    6'b100100: alu_ctrl_d = 4'b0000;
                    6'b100101: alu_ctrl_d = 4'b0001;
                    6'b101010: alu_ctrl_d = 4'b0111;
                    6'b100111: alu_ctrl_d = 4'b1100;
                    default:   alu_ctrl_d = 4'b0010;
                endcase
            end
            default: alu_ctrl_d = 4'b0010;
        endcase

`ifdef CTRL_ILLEGAL_DETECT_EN
        // An instruction is unsupported if its opcode is outside the subset,
        // or it is R-type with a funct outside the ALU table.
        suppress = 1'b1;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ: suppress = 1'b0;
            OP_RTYPE: begin
                case (funct)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010, 6'b100111: suppress = 1'b0;
                    default:                         suppress = 1'b1;
                endcase
            end
            default: suppress = 1'b1;
        endcase
        illegal_d = suppress && (state_d != IDLE);
`else
        suppress  = 1'b0;
        illegal_d = 1'b0;
`endif

        reg_dst_d    = dec_reg_dst;
        alu_src_d    = dec_alu_src;
        mem_to_reg_d = dec_mem_to_reg;
        branch_d     = dec_branch    && !suppress && (state_d == EX);
        mem_read_d   = dec_mem_read  && !suppress && (state_d == MEM);
        mem_write_d  = dec_mem_write && !suppress && (state_d == MEM);
        reg_write_d  = dec_reg_write && !suppress && (state_d == WB);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == WB);
    end

    // State, instruction register and registered outputs. Reset is folded
    // into the next-state logic above, so every flop simply loads its _d.
    always_ff @(posedge clock) begin
        state_q      <= state_d;
        instr_q      <= instr_d;
        reg_dst_q    <= reg_dst_d;
        alu_src_q    <= alu_src_d;
        mem_to_reg_q <= mem_to_reg_d;
        alu_ctrl_q   <= alu_ctrl_d;
        branch_q     <= branch_d;
        mem_read_q   <= mem_read_d;
        mem_write_q  <= mem_write_d;
        reg_write_q  <= reg_write_d;
        busy_q       <= busy_d;
        done_q       <= done_d;
        illegal_q    <= illegal_d;
    end

    assign bus.RegDst   = reg_dst_q;
    assign bus.ALUSrc   = alu_src_q;
    assign bus.MemtoReg = mem_to_reg_q;
    assign bus.ALUCtrl  = alu_ctrl_q;
    assign bus.Branch   = branch_q;
    assign bus.MemRead  = mem_read_q;
    assign bus.MemWrite = mem_write_q;
    assign bus.RegWrite = reg_write_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_control_path.sv
// ---------------------------------------------------------------------------
// tb_control_path
//
// Self-checking bench for control_path. A reference model tracks the
// captured instruction and how many cycles have elapsed since capture
// (1 = ID ... 4 = WB, 0 = idle) and derives every expected output from the
// instruction-class rules. Directed instructions are followed by a
// randomized run with random captures, back-to-back captures and resets.
// Honors CTRL_ILLEGAL_DETECT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_control_path;

    logic clock;
    logic reset;

    control_path_if bus();

    control_path dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // 10 time-unit clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state.
    logic [31:0] mInstr = 32'h0;
    int          mPhase = 0;

`ifdef CTRL_ILLEGAL_DETECT_EN
    localparam bit DETECT = 1'b1;
`else
    localparam bit DETECT = 1'b0;
`endif

    // Advance the model by one clock edge using the inputs present at it.
    task automatic modelEdge();
        if (!reset) begin
            mInstr = 32'h0;
            mPhase = 0;
        end else if (bus.newinstr) begin
            mInstr = bus.instrword;
            mPhase = 1;
        end else if (mPhase != 0) begin
            mPhase = (mPhase == 4) ? 0 : mPhase + 1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        nChecks++;
        assert (got === exp)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h (instr %h phase %0d)",
                   tag, got, exp, mInstr, mPhase);
        end
    endtask

    // Compare every output against what the model says for this cycle.
    task automatic checkOutput();
        logic [5:0] op;
        logic [5:0] fn;
        bit isR, isLw, isSw, isBeq, fnListed, bad, kill;
        logic [3:0] expAlu;
        op = mInstr[31:26];
        fn = mInstr[5:0];
        isR   = (op == 6'd0);
        isLw  = (op == 6'd35);
        isSw  = (op == 6'd43);
        isBeq = (op == 6'd4);
        fnListed = 1'b1;
        expAlu   = 4'd2;
        if (isBeq) expAlu = 4'd6;
        else if (isR) begin
            case (fn)
                6'd32:   expAlu = 4'd2;
                6'd34:   expAlu = 4'd6;
                6'd36:   expAlu = 4'd0;
                6'd37:   expAlu = 4'd1;
                6'd42:   expAlu = 4'd7;
                6'd39:   expAlu = 4'd12;
                default: begin expAlu = 4'd2; fnListed = 1'b0; end
            endcase
        end
        bad  = !(isLw || isSw || isBeq || (isR && fnListed));
        kill = DETECT && bad;

        check("RegDst",   {3'b0, bus.RegDst},   {3'b0, isR});
        check("ALUSrc",   {3'b0, bus.ALUSrc},   {3'b0, isLw || isSw});
        check("MemtoReg", {3'b0, bus.MemtoReg}, {3'b0, isLw});
        check("ALUCtrl",  bus.ALUCtrl,          expAlu);
        check("Branch",   {3'b0, bus.Branch},   {3'b0, isBeq && mPhase == 2 && !kill});
        check("MemRead",  {3'b0, bus.MemRead},  {3'b0, isLw && mPhase == 3 && !kill});
        check("MemWrite", {3'b0, bus.MemWrite}, {3'b0, isSw && mPhase == 3 && !kill});
        check("RegWrite", {3'b0, bus.RegWrite}, {3'b0, (isR || isLw) && mPhase == 4 && !kill});
        check("busy",     {3'b0, bus.busy},     {3'b0, mPhase != 0});
        check("done",     {3'b0, bus.done},     {3'b0, mPhase == 4});
        check("illegal",  {3'b0, bus.illegal},  {3'b0, DETECT && bad && mPhase != 0});
    endtask

    // One clock: inputs are already set; update the model at the edge and
    // compare on the following falling edge.
    task automatic applyStimulus(input logic rstN, input logic ni, input logic [31:0] word);
        reset         = rstN;
        bus.newinstr  = ni;
        bus.instrword = word;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkOutput();
    endtask

    // Capture one instruction and let it run to idle (cycles 1..5 checked).
    task automatic runInstr(input logic [31:0] word);
        applyStimulus(1'b1, 1'b1, word);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, $urandom);
    endtask

    function automatic logic [31:0] randomInstr();
        logic [31:0] w;
        logic [5:0] functs [6];
        functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39};
        w = $urandom;
        case ($urandom_range(0, 6))
            0, 1: begin w[31:26] = 6'd0; w[5:0] = functs[$urandom_range(0, 5)]; end
            2:    w[31:26] = 6'd0;
            3:    w[31:26] = 6'd35;
            4:    w[31:26] = 6'd43;
            5:    w[31:26] = 6'd4;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        reset         = 1'b0;
        bus.newinstr  = 1'b0;
        bus.instrword = 32'h0;

        // Reset, then idle with decode of an all-zero word.
        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 32'h0);
        check("rst_RegDst",  {3'b0, bus.RegDst}, 4'd1);
        check("rst_ALUCtrl", bus.ALUCtrl, 4'b0010);
        check("rst_busy",    {3'b0, bus.busy}, 4'd0);

        // Directed instructions from the test plan.
        runInstr(32'h0022_1820);   // add
        runInstr(32'h8C22_0004);   // lw
        runInstr(32'hAC22_0008);   // sw
        runInstr(32'h1022_0003);   // beq
        runInstr(32'h0022_182A);   // slt
        runInstr(32'h0022_1827);   // nor
        runInstr(32'hFC00_0000);   // unsupported opcode
        runInstr(32'h0022_183F);   // R-type, unlisted funct

        // lw with reset asserted during cycle 3: no RegWrite afterwards.
        applyStimulus(1'b1, 1'b1, 32'h8C22_0004);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);

        // New instruction arriving in WB of the previous one.
        applyStimulus(1'b1, 1'b1, 32'h8C22_0004);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);
        runInstr(32'hAC22_0008);

        // Newinstr held high for several cycles, then released.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, randomInstr());
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 32'h0);

        // Randomized run.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) != 0),
                          ($urandom_range(0, 3) == 0),
                          randomInstr());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
